// File: rtl/seq_mult_addsub.sv
// Sequential shift-add multiplier: WIDTH iterations of ADD then SHIFT on a
// WIDTH+1-bit {X,A} accumulator. Signed mode uses a final subtract of S.
module seq_mult_addsub #(
    parameter int WIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 ready,
    output logic                 done,
    output logic                 x_bit,
    output logic [2*WIDTH-1:0]   product,
    output logic [1:0]           state_o
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             x_q, x_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CW-1:0]    count_q, count_d;
    logic             sgn_q, sgn_d;

    logic [WIDTH:0]   ext_a;
    logic [WIDTH:0]   ext_s;
    logic [WIDTH:0]   addend;
    logic [WIDTH:0]   sum;
    logic             sub;

    // Signed operands weigh the MSB as -2^(W-1), so the last partial product is subtracted.
    always_comb begin
        sub    = sgn_q && (count_q == LAST);
        ext_a  = {sgn_q & a_q[WIDTH-1], a_q};
        ext_s  = {sgn_q & s_q[WIDTH-1], s_q};
        addend = sub ? ~ext_s : ext_s;
        sum    = ext_a + addend + {{WIDTH{1'b0}}, sub};
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        count_d = count_q;
        sgn_d   = sgn_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = 1'b0;
                    a_d     = '0;
                    b_d     = multiplier;
                    s_d     = multiplicand;
                    count_d = '0;
                    sgn_d   = signed_mode;
                    state_d = ADD;
                end
            end
            ADD: begin
                if (b_q[0]) begin
                    {x_d, a_d} = sum;
                end
                state_d = SHIFT;
            end
            SHIFT: begin
                x_d     = sgn_q & x_q;
                a_d     = {x_q, a_q[WIDTH-1:1]};
                b_d     = {a_q[0], b_q[WIDTH-1:1]};
                count_d = count_q + CW'(1);
                state_d = (count_q == LAST) ? DONE : ADD;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            x_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            count_q <= '0;
            sgn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            count_q <= count_d;
            sgn_q   <= sgn_d;
        end
    end

    assign ready   = (state_q == IDLE);
    assign done    = (state_q == DONE);
    assign x_bit   = x_q;
    assign product = {a_q, b_q};
    assign state_o = state_q;

endmodule

// File: tb/tb_seq_mult_addsub.sv
// Bench for seq_mult_addsub: arithmetic/timing model with per-cycle compare,
// plus directed vectors with hand-computed products, for WIDTH=8 and WIDTH=4.
module tb_seq_mult_addsub;

    logic        Clk;
    logic        Reset_n;

    logic        start8, sm8;
    logic [7:0]  mcand8, mult8;
    logic        ready8, done8, x8;
    logic [15:0] prod8;
    logic [1:0]  st8;

    logic        start4, sm4;
    logic [3:0]  mcand4, mult4;
    logic        ready4, done4, x4;
    logic [7:0]  prod4;
    logic [1:0]  st4;

    int n_cmp  = 0;
    int n_fail = 0;

    seq_mult_addsub #(.WIDTH(8)) dut8 (
        .Clk(Clk), .Reset_n(Reset_n), .start(start8), .signed_mode(sm8),
        .multiplicand(mcand8), .multiplier(mult8), .ready(ready8), .done(done8),
        .x_bit(x8), .product(prod8), .state_o(st8)
    );

    seq_mult_addsub #(.WIDTH(4)) dut4 (
        .Clk(Clk), .Reset_n(Reset_n), .start(start4), .signed_mode(sm4),
        .multiplicand(mcand4), .multiplier(mult4), .ready(ready4), .done(done4),
        .x_bit(x4), .product(prod4), .state_o(st4)
    );

    // clock / reset
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference product from plain integer arithmetic; returns {x_bit, product}.
    function automatic logic [32:0] mul_model(input int w, input logic sg,
                                              input logic [15:0] s, input logic [15:0] b);
        longint sv, bv, p, mask;
        logic [31:0] pr;
        logic        xb;
        sv = longint'(s);
        bv = longint'(b);
        if (sg && s[w-1]) sv = sv - (longint'(1) << w);
        if (sg && b[w-1]) bv = bv - (longint'(1) << w);
        p    = sv * bv;
        mask = (longint'(1) << (2 * w)) - 1;
        pr   = 32'(p & mask);
        xb   = sg ? pr[2*w-1] : 1'b0;
        return {xb, pr};
    endfunction

    // scoreboard: model of acceptance/latency and expected results
    logic [32:0] exp_q8[$];
    logic [32:0] exp_q4[$];
    int          busy8, busy4;
    logic [32:0] hold8, hold4;

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            busy8 <= 0;
            busy4 <= 0;
            exp_q8.delete();
            exp_q4.delete();
        end else begin
            if (busy8 != 0) busy8 <= busy8 - 1;
            else if (start8) begin
                busy8 <= 2 * 8 + 1;
                exp_q8.push_back(mul_model(8, sm8, {8'h00, mcand8}, {8'h00, mult8}));
            end
            if (busy4 != 0) busy4 <= busy4 - 1;
            else if (start4) begin
                busy4 <= 2 * 4 + 1;
                exp_q4.push_back(mul_model(4, sm4, {12'h000, mcand4}, {12'h000, mult4}));
            end
        end
    end

    // compare process: handshake every cycle, result on done and while idle
    always @(negedge Clk) begin
        logic [32:0] e;
        if (!Reset_n) begin
            hold8 <= '0;
            hold4 <= '0;
        end else begin
            check("done8", 32'(done8), 32'(busy8 == 1));
            check("ready8", 32'(ready8), 32'(busy8 == 0));
            if (busy8 == 1) begin
                if (exp_q8.size() == 0) check("queue8_empty", 32'd1, 32'd0);
                else begin
                    e = exp_q8.pop_front();
                    check("prod8_done", 32'(prod8), e[31:0]);
                    check("x8_done", 32'(x8), 32'(e[32]));
                    hold8 <= e;
                end
            end else if (busy8 == 0) begin
                check("prod8_idle", 32'(prod8), hold8[31:0]);
                check("x8_idle", 32'(x8), 32'(hold8[32]));
            end
            check("done4", 32'(done4), 32'(busy4 == 1));
            check("ready4", 32'(ready4), 32'(busy4 == 0));
            if (busy4 == 1) begin
                if (exp_q4.size() == 0) check("queue4_empty", 32'd1, 32'd0);
                else begin
                    e = exp_q4.pop_front();
                    check("prod4_done", 32'(prod4), e[31:0]);
                    check("x4_done", 32'(x4), 32'(e[32]));
                    hold4 <= e;
                end
            end else if (busy4 == 0) begin
                check("prod4_idle", 32'(prod4), hold4[31:0]);
                check("x4_idle", 32'(x4), 32'(hold4[32]));
            end
        end
    end

    // driver tasks
    task automatic wait_done8(output int lat);
        lat = 0;
        while (!done8 && lat < 40) begin
            @(posedge Clk);
            lat++;
            #1;
        end
    endtask

    task automatic op8(input logic [7:0] s, input logic [7:0] b, input logic sg,
                       input logic [15:0] exp, input string name);
        int lat;
        @(negedge Clk);
        mcand8 = s; mult8 = b; sm8 = sg; start8 = 1'b1;
        @(posedge Clk);
        #1;
        start8 = 1'b0;
        mcand8 = 8'($urandom_range(0, 255));
        mult8  = 8'($urandom_range(0, 255));
        sm8    = 1'($urandom_range(0, 1));
        wait_done8(lat);
        check({name, "_lat"}, 32'(lat), 32'd16);
        check(name, 32'(prod8), 32'(exp));
        @(posedge Clk);
    endtask

    task automatic op4(input logic [3:0] s, input logic [3:0] b, input logic sg,
                       input logic [7:0] exp, input string name);
        int lat;
        @(negedge Clk);
        mcand4 = s; mult4 = b; sm4 = sg; start4 = 1'b1;
        @(posedge Clk);
        #1;
        start4 = 1'b0;
        mcand4 = 4'($urandom_range(0, 15));
        mult4  = 4'($urandom_range(0, 15));
        lat = 0;
        while (!done4 && lat < 30) begin
            @(posedge Clk);
            lat++;
            #1;
        end
        check({name, "_lat"}, 32'(lat), 32'd8);
        check(name, 32'(prod4), 32'(exp));
        @(posedge Clk);
    endtask

    initial begin
        int lat;
        Reset_n = 1'b1;
        start8 = 1'b0; sm8 = 1'b0; mcand8 = '0; mult8 = '0;
        start4 = 1'b0; sm4 = 1'b0; mcand4 = '0; mult4 = '0;

        // asynchronous reset, checked before any clock edge
        #3 Reset_n = 1'b0;
        #1;
        check("rst_ready", 32'(ready8), 32'd1);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_prod", 32'(prod8), 32'h0000);
        check("rst_x", 32'(x8), 32'd0);
        @(negedge Clk);
        #2 Reset_n = 1'b1;

        op8(8'h07, 8'hFD, 1'b1, 16'hFFEB, "s_7xm3");
        op8(8'h80, 8'h80, 1'b1, 16'h4000, "s_min_min");
        op8(8'h80, 8'h7F, 1'b1, 16'hC080, "s_min_max");
        op8(8'h00, 8'h80, 1'b1, 16'h0000, "s_zero_min");
        op8(8'h7F, 8'h7F, 1'b1, 16'h3F01, "s_max_max");
        op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_ff_ff");
        op8(8'h80, 8'h02, 1'b0, 16'h0100, "u_80_02");
        op8(8'hFF, 8'hFF, 1'b1, 16'h0001, "s_m1_m1");

        // starts while busy and in DONE are ignored; first IDLE cycle accepts
        @(negedge Clk);
        mcand8 = 8'h07; mult8 = 8'hFD; sm8 = 1'b1; start8 = 1'b1;
        @(posedge Clk);
        #1;
        start8 = 1'b0; mcand8 = 8'hA5; mult8 = 8'h3C; sm8 = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        start8 = 1'b1; mcand8 = 8'h11; mult8 = 8'h22;
        @(posedge Clk);
        #1;
        start8 = 1'b0;
        wait_done8(lat);
        check("hs_done_seen", 32'(done8), 32'd1);
        check("hs_first", 32'(prod8), 32'hFFEB);
        start8 = 1'b1; mcand8 = 8'h05; mult8 = 8'h03; sm8 = 1'b0;
        @(posedge Clk);
        #1;
        check("hs_idle_ready", 32'(ready8), 32'd1);
        @(posedge Clk);
        #1;
        start8 = 1'b0;
        check("hs_accepted", 32'(ready8), 32'd0);
        wait_done8(lat);
        check("hs_lat", 32'(lat), 32'd16);
        check("hs_second", 32'(prod8), 32'h000F);
        @(posedge Clk);

        // reset in the middle of iteration 3 aborts cleanly
        @(negedge Clk);
        mcand8 = 8'h07; mult8 = 8'hFD; sm8 = 1'b1; start8 = 1'b1;
        @(posedge Clk);
        #1;
        start8 = 1'b0;
        repeat (6) @(posedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        check("abort_ready", 32'(ready8), 32'd1);
        check("abort_done", 32'(done8), 32'd0);
        check("abort_prod", 32'(prod8), 32'h0000);
        check("abort_x", 32'(x8), 32'd0);
        @(negedge Clk);
        #2 Reset_n = 1'b1;
        op8(8'h05, 8'h03, 1'b1, 16'h000F, "after_abort");

        op4(4'h8, 4'h8, 1'b1, 8'h40, "w4_min_min");
        op4(4'hF, 4'hF, 1'b0, 8'hE1, "w4_u_f_f");
        op4(4'h7, 4'h9, 1'b1, 8'hCF, "w4_s_7xm7");

        repeat (3) @(posedge Clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
